// File: rtl/sha256_pad.sv
// SHA-256 message padder: packs DATA_W-bit beats into 512-bit blocks and appends FIPS 180-4 padding.
// Define SHA256_PAD_BYTESWAP_EN to accept little-endian input beats (first byte at m_data[7:0]).
module sha256_pad #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 61
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        m_valid,
   output logic                        m_ready,
   input  logic [DATA_W-1:0]           m_data,
   input  logic                        m_last,
   input  logic [$clog2(DATA_W/8)-1:0] m_last_sz,
   output logic                        b_valid,
   input  logic                        b_ready,
   output logic [511:0]                b_data,
   output logic                        b_first,
   output logic                        b_last
);
   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned BEATS = 512 / DATA_W;
   localparam int unsigned K_W   = $clog2(BEATS);

   typedef enum logic [1:0] {StFill, StEmit, StLenBlk} state_e;

   state_e           state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pad_pending_q, pad_pending_d;
   logic             marker_owed_q, marker_owed_d;
   logic             first_q, first_d;
   logic             m_ready_q, m_ready_d;
   logic             b_valid_q, b_valid_d;
   logic             b_first_q, b_first_d;
   logic             b_last_q, b_last_d;
   logic [511:0]     b_data_q, b_data_d;

   logic [DATA_W-1:0] beat;
   logic [6:0]        nbytes, e_w;
   logic [CNT_W-1:0]  cnt_sum;
   logic [63:0]       len_w;
   logic [511:0]      blk_w;
   logic              accept;

`ifdef SHA256_PAD_BYTESWAP_EN
   always_comb begin
      beat = '0;
      for (int j = 0; j < BYTES; j++) beat[DATA_W-1-8*j -: 8] = m_data[8*j +: 8];
   end
`else
   assign beat = m_data;
`endif

   assign accept  = (state_q == StFill) && m_valid && m_ready_q;
   assign nbytes  = (m_last && (m_last_sz != '0)) ? 7'(m_last_sz) : 7'(BYTES);
   assign e_w     = 7'(k_q) * 7'(BYTES) + nbytes;
   assign cnt_sum = cnt_q + CNT_W'(nbytes);
   assign len_w   = 64'((state_q == StLenBlk) ? cnt_q : cnt_sum) << 3;

   // Block as it stands after the current beat; b_data_q doubles as the fill buffer.
   always_comb begin
      blk_w = b_data_q;
      for (int s = 0; s < BEATS; s++) begin
         if (k_q == K_W'(s)) blk_w[511-s*DATA_W -: DATA_W] = beat;
      end
      if (m_last) begin
         for (int i = 0; i < 64; i++) begin
            if (7'(i) == e_w) blk_w[511-8*i -: 8] = 8'h80;
            else if (7'(i) > e_w) blk_w[511-8*i -: 8] = 8'h00;
         end
         if (e_w <= 7'd55) blk_w[63:0] = len_w;
      end
   end

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      cnt_d         = cnt_q;
      pad_pending_d = pad_pending_q;
      marker_owed_d = marker_owed_q;
      first_d       = first_q;
      m_ready_d     = m_ready_q;
      b_valid_d     = b_valid_q;
      b_data_d      = b_data_q;
      b_first_d     = b_first_q;
      b_last_d      = b_last_q;
      unique case (state_q)
         StFill: begin
            m_ready_d = 1'b1;
            if (accept) begin
               cnt_d    = cnt_sum;
               b_data_d = blk_w;
               k_d      = k_q + K_W'(1);
               if (m_last || (k_q == K_W'(BEATS - 1))) begin
                  state_d       = StEmit;
                  m_ready_d     = 1'b0;
                  b_valid_d     = 1'b1;
                  k_d           = '0;
                  b_first_d     = first_q;
                  b_last_d      = m_last && (e_w <= 7'd55);
                  first_d       = m_last && (e_w <= 7'd55);
                  pad_pending_d = m_last && (e_w > 7'd55);
                  marker_owed_d = m_last && (e_w == 7'd64);
                  if (m_last && (e_w <= 7'd55)) cnt_d = '0;
               end
            end
         end
         StEmit: begin
            if (b_ready) begin
               b_valid_d = 1'b0;
               if (pad_pending_q) begin
                  state_d       = StLenBlk;
                  pad_pending_d = 1'b0;
               end else begin
                  state_d   = StFill;
                  m_ready_d = 1'b1;
               end
            end
         end
         StLenBlk: begin
            // First cycle builds the length-only block, then it is offered.
            if (!b_valid_q) begin
               b_data_d          = '0;
               b_data_d[511:504] = marker_owed_q ? 8'h80 : 8'h00;
               b_data_d[63:0]    = len_w;
               b_valid_d         = 1'b1;
               b_first_d         = 1'b0;
               b_last_d          = 1'b1;
            end else if (b_ready) begin
               state_d       = StFill;
               b_valid_d     = 1'b0;
               m_ready_d     = 1'b1;
               cnt_d         = '0;
               marker_owed_d = 1'b0;
               first_d       = 1'b1;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StFill;
         k_q           <= '0;
         cnt_q         <= '0;
         pad_pending_q <= 1'b0;
         marker_owed_q <= 1'b0;
         first_q       <= 1'b1;
         m_ready_q     <= 1'b0;
         b_valid_q     <= 1'b0;
         b_data_q      <= '0;
         b_first_q     <= 1'b0;
         b_last_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         cnt_q         <= cnt_d;
         pad_pending_q <= pad_pending_d;
         marker_owed_q <= marker_owed_d;
         first_q       <= first_d;
         m_ready_q     <= m_ready_d;
         b_valid_q     <= b_valid_d;
         b_data_q      <= b_data_d;
         b_first_q     <= b_first_d;
         b_last_q      <= b_last_d;
      end
   end

   assign m_ready = m_ready_q;
   assign b_valid = b_valid_q;
   assign b_data  = b_data_q;
   assign b_first = b_first_q;
   assign b_last  = b_last_q;

endmodule
